access_ctrl_seq: RTL and testbench
==================================

Name: access_ctrl_seq

Overview:
Sequential, parametrised access checker for the profile/functionality interface. It holds a programmable permission table with one entry per profile. Each accepted request is checked against the table, and the result is registered. Denied requests pass the functionality through as all-zero. After MAX_FAILS consecutive denials the block enters a timed lockout, during which it accepts no requests.

Parameters:
PROFILE_W, 3, profile code width; the table has 2**PROFILE_W entries.
FUNC_W, 3, functionality vector width; one bit per functionality.
MAX_FAILS, 3, consecutive denials that trigger lockout (>=1).
LOCK_CYCLES, 8, lockout duration in clock cycles (>=1).

Ports:
clk  input  1  single clock; all state updates on the rising edge.
rst  input  1  synchronous, active-high reset.
cfg_we  input  1  permission table write enable.
cfg_profile  input  PROFILE_W  table entry to write.
cfg_perm  input  FUNC_W  permission mask to store; bit i=1 allows functionality bit i.
req_valid  input  1  request present.
req_ready  output  1  block can accept a request this cycle.
req_profile  input  PROFILE_W  requesting profile.
req_func  input  FUNC_W  requested functionality vector.
resp_valid  output  1  one-cycle pulse, response valid.
resp_func  output  FUNC_W  copy of req_func if granted, else all-zero.
resp_grant  output  1  1 = granted, 0 = denied; meaningful only while resp_valid=1.
locked  output  1  lockout active.
fail_count  output  clog2(MAX_FAILS+1)  current count of consecutive denials.

Behaviour:
- Reset (rst=1 at a clock edge) clears everything:
  - all table entries = 0 (deny all);
  - state = IDLE;
  - resp_valid=0, resp_func=0, resp_grant=0, locked=0, fail_count=0;
  - lock timer = 0.
- req_ready is combinational: 1 in IDLE, 0 in LOCKED. It is 0 while rst=1.
- Accept: a request is accepted when req_valid && req_ready at the clock edge.
- Latency is 1 cycle. The response registers appear at the edge after acceptance, and resp_valid is high for exactly that one cycle.
- Back-to-back accepts in consecutive cycles give consecutive responses. There is no internal queue.
- Grant rule:
  - grant = (req_func != 0) && ((req_func & ~perm[req_profile]) == 0);
  - on grant, resp_func = req_func;
  - otherwise resp_func = 0 and resp_grant = 0.
  - A request with req_func = 0 is denied and counts as a failure.
- Table writes:
  - a write with cfg_we=1 updates the entry at the same edge;
  - a request accepted in that same cycle sees the old entry, even when the profiles match;
  - writes are accepted in every state, including LOCKED.
- fail_count:
  - a grant clears it to 0;
  - a denial increments it;
  - it saturates at MAX_FAILS.
- State machine, IDLE to LOCKED:
  - trigger: an accepted request is denied while fail_count == MAX_FAILS-1;
  - at that edge: the denial response is issued, fail_count is set to MAX_FAILS, locked=1, state = LOCKED, lock timer = LOCK_CYCLES-1;
  - req_ready therefore drops in the same cycle the final denial is visible.
- State machine, LOCKED:
  - req_ready=0 and requests are ignored, with no responses;
  - the timer decrements each cycle;
  - on the edge where the timer is 0: state = IDLE, locked=0, fail_count=0;
  - total locked duration is exactly LOCK_CYCLES cycles;
  - a request presented on the first IDLE cycle is accepted.
- Lockout on the first denial: with MAX_FAILS=1, the first denial locks immediately.
- Reset mid-operation: rst has priority over every other event. A pending response is dropped (resp_valid=0 next cycle), a lockout is aborted, and the table is cleared.
- Outputs are registered except req_ready. resp_func and resp_grant hold their last values while resp_valid=0.

Test Plan:
1. Reset, then request profile 5 func 3'b010 -> response next cycle: resp_valid=1, resp_grant=0, resp_func=000, fail_count=1.
2. Write perm[5]=3'b011. Next cycle request profile 5 func 3'b010 -> resp_grant=1, resp_func=010, fail_count=0. Then request func 3'b110 -> denied, resp_func=000.
3. Same-cycle write perm[2]=3'b100 and request profile 2 func 3'b100 -> denied (old entry). The repeat request next cycle -> granted, resp_func=100.
4. Three consecutive denials -> third response has locked=1 and req_ready=0. Requests are ignored for exactly 8 cycles. On cycle 9, locked=0, fail_count=0, and a request is accepted.
5. Back-to-back requests on 4 consecutive cycles: grant, deny, grant, deny -> 4 consecutive resp_valid pulses with matching resp_func. fail_count goes 0,1,0,1.
6. rst asserted 3 cycles into lockout with perm[5]=011 -> next cycle locked=0, req_ready=1, and a request for profile 5 func 010 is denied (table cleared).

Source files
------------

// File: rtl/access_ctrl_seq.sv
// access_ctrl_seq
// Sequential access checker for the profile/functionality interface.
// A programmable permission table (one mask per profile) is consulted for
// every accepted request; the verdict is registered and presented one cycle
// later. A run of MAX_FAILS consecutive denials puts the block into a timed
// lockout of LOCK_CYCLES cycles during which no requests are accepted.
//
// Ports:
//   clk          - clock, all state updates on the rising edge
//   rst          - synchronous active-high reset
//   cfg_we       - permission table write enable
//   cfg_profile  - table entry to write
//   cfg_perm     - permission mask to store (bit i allows functionality bit i)
//   req_valid    - request present
//   req_ready    - block can accept a request this cycle (combinational)
//   req_profile  - requesting profile
//   req_func     - requested functionality vector
//   resp_valid   - one-cycle response pulse
//   resp_func    - req_func if granted, otherwise all-zero
//   resp_grant   - 1 = granted, 0 = denied (meaningful with resp_valid)
//   locked       - lockout active
//   fail_count   - current count of consecutive denials (saturates)
module access_ctrl_seq #(
    parameter int PROFILE_W   = 3,
    parameter int FUNC_W      = 3,
    parameter int MAX_FAILS   = 3,
    parameter int LOCK_CYCLES = 8,
    parameter int FC_W        = $clog2(MAX_FAILS + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cfg_we,
    input  logic [PROFILE_W-1:0] cfg_profile,
    input  logic [FUNC_W-1:0]    cfg_perm,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [PROFILE_W-1:0] req_profile,
    input  logic [FUNC_W-1:0]    req_func,
    output logic                 resp_valid,
    output logic [FUNC_W-1:0]    resp_func,
    output logic                 resp_grant,
    output logic                 locked,
    output logic [FC_W-1:0]      fail_count
);

    localparam int N_PROFILES = 2 ** PROFILE_W;
    localparam int TMR_W      = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

    localparam logic [FC_W-1:0]  FAIL_MAX  = FC_W'(MAX_FAILS);
    localparam logic [FC_W-1:0]  FAIL_LAST = FC_W'(MAX_FAILS - 1);
    localparam logic [TMR_W-1:0] TMR_LOAD  = TMR_W'(LOCK_CYCLES - 1);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    // A request is granted only if it asks for something and every asked-for
    // bit is present in the profile's mask; an empty request is a denial.
    function automatic logic perm_grants(input logic [FUNC_W-1:0] func,
                                         input logic [FUNC_W-1:0] perm);
        perm_grants = (func != {FUNC_W{1'b0}}) &&
                      ((func & ~perm) == {FUNC_W{1'b0}});
    endfunction

    logic [FUNC_W-1:0] perm_r [N_PROFILES];

    state_t            state_r,      state_s;
    logic [TMR_W-1:0]  timer_r,      timer_s;
    logic [FC_W-1:0]   fail_r,       fail_s;
    logic              resp_valid_r, resp_valid_s;
    logic [FUNC_W-1:0] resp_func_r,  resp_func_s;
    logic              resp_grant_r, resp_grant_s;
    logic              locked_r,     locked_s;

    logic accept_s;
    logic grant_s;

    assign req_ready = (state_r == ST_IDLE) && !rst;
    assign accept_s  = req_valid && req_ready;
    // Reads the table before this edge's write lands, so a same-cycle write
    // to the requesting profile is not yet visible.
    assign grant_s   = perm_grants(req_func, perm_r[req_profile]);

    assign resp_valid = resp_valid_r;
    assign resp_func  = resp_func_r;
    assign resp_grant = resp_grant_r;
    assign locked     = locked_r;
    assign fail_count = fail_r;

    // Permission table: cleared on reset, written in any state when cfg_we is high
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_PROFILES; i++) begin
                perm_r[i] <= {FUNC_W{1'b0}};
            end
        end else if (cfg_we) begin
            perm_r[cfg_profile] <= cfg_perm;
        end
    end

    // Next-state and next-output logic for the IDLE/LOCKED controller
    always_comb begin
        state_s      = state_r;
        timer_s      = timer_r;
        fail_s       = fail_r;
        resp_valid_s = 1'b0;
        resp_func_s  = resp_func_r;
        resp_grant_s = resp_grant_r;
        locked_s     = locked_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    resp_valid_s = 1'b1;
                    if (grant_s) begin
                        resp_func_s  = req_func;
                        resp_grant_s = 1'b1;
                        fail_s       = {FC_W{1'b0}};
                    end else begin
                        resp_func_s  = {FUNC_W{1'b0}};
                        resp_grant_s = 1'b0;
                        if (fail_r == FAIL_LAST) begin
                            fail_s   = FAIL_MAX;
                            locked_s = 1'b1;
                            state_s  = ST_LOCKED;
                            timer_s  = TMR_LOAD;
                        end else if (fail_r < FAIL_MAX) begin
                            fail_s = fail_r + {{(FC_W-1){1'b0}}, 1'b1};
                        end else begin
                            fail_s = FAIL_MAX;
                        end
                    end
                end else begin
                    resp_valid_s = 1'b0;
                end
            end
            ST_LOCKED: begin
                // Timer counts LOCK_CYCLES-1 down to 0, so the lockout lasts
                // exactly LOCK_CYCLES cycles.
                if (timer_r == {TMR_W{1'b0}}) begin
                    state_s  = ST_IDLE;
                    locked_s = 1'b0;
                    fail_s   = {FC_W{1'b0}};
                end else begin
                    timer_s = timer_r - {{(TMR_W-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_s  = ST_IDLE;
                locked_s = 1'b0;
                timer_s  = {TMR_W{1'b0}};
            end
        endcase
    end

    // Controller and response registers; reset overrides every other event
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            timer_r      <= {TMR_W{1'b0}};
            fail_r       <= {FC_W{1'b0}};
            resp_valid_r <= 1'b0;
            resp_func_r  <= {FUNC_W{1'b0}};
            resp_grant_r <= 1'b0;
            locked_r     <= 1'b0;
        end else begin
            state_r      <= state_s;
            timer_r      <= timer_s;
            fail_r       <= fail_s;
            resp_valid_r <= resp_valid_s;
            resp_func_r  <= resp_func_s;
            resp_grant_r <= resp_grant_s;
            locked_r     <= locked_s;
        end
    end

endmodule

// File: tb/tb_access_ctrl_seq.sv
// Testbench for access_ctrl_seq: directed scenarios with literal expectations
// followed by randomized traffic, all checked every cycle against a
// behavioural model of the permission/lockout rules.
module tb_access_ctrl_seq;

    localparam int PW  = 3;
    localparam int FW  = 3;
    localparam int MF  = 3;
    localparam int LC  = 8;
    localparam int FCW = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cfg_we = 1'b0;
    logic [PW-1:0] cfg_profile = '0;
    logic [FW-1:0] cfg_perm = '0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [PW-1:0] req_profile = '0;
    logic [FW-1:0] req_func = '0;
    logic          resp_valid;
    logic [FW-1:0] resp_func;
    logic          resp_grant;
    logic          locked;
    logic [FCW-1:0] fail_count;

    always #5 clk = ~clk;

    access_ctrl_seq #(
        .PROFILE_W(PW), .FUNC_W(FW), .MAX_FAILS(MF), .LOCK_CYCLES(LC)
    ) dut (
        .clk(clk), .rst(rst),
        .cfg_we(cfg_we), .cfg_profile(cfg_profile), .cfg_perm(cfg_perm),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_profile(req_profile), .req_func(req_func),
        .resp_valid(resp_valid), .resp_func(resp_func), .resp_grant(resp_grant),
        .locked(locked), .fail_count(fail_count)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model state
    logic [FW-1:0] perm_m [8];
    int            fail_m   = 0;
    int            lock_m   = 0;   // locked cycles still to run
    bit            valid_m  = 1'b0;
    bit            grant_m  = 1'b0;
    logic [FW-1:0] func_m   = '0;
    bit            live     = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_outputs();
        if (live) begin
            check("resp_valid", resp_valid, valid_m);
            check("resp_grant", resp_grant, grant_m);
            check("resp_func",  resp_func,  func_m);
            check("locked",     locked,     (lock_m > 0));
            check("fail_count", fail_count, fail_m);
        end
    endtask

    // Apply the rules to the inputs sampled at the current rising edge
    task automatic model_edge();
        bit ok;
        bit ready;
        if (rst) begin
            for (int i = 0; i < 8; i++) perm_m[i] = '0;
            fail_m = 0; lock_m = 0;
            valid_m = 0; grant_m = 0; func_m = '0;
            live = 1'b1;
        end else begin
            ready = (lock_m == 0);
            valid_m = 1'b0;
            if (lock_m > 0) begin
                lock_m--;
                if (lock_m == 0) fail_m = 0;
            end
            if (ready && req_valid) begin
                ok = (req_func != 0);
                for (int b = 0; b < FW; b++)
                    if (req_func[b] && !perm_m[req_profile][b]) ok = 1'b0;
                valid_m = 1'b1;
                grant_m = ok;
                func_m  = ok ? req_func : '0;
                if (ok) fail_m = 0;
                else begin
                    fail_m = (fail_m + 1 > MF) ? MF : fail_m + 1;
                    if (fail_m == MF) lock_m = LC;
                end
            end
            if (cfg_we) perm_m[cfg_profile] = cfg_perm;
        end
    endtask

    task automatic cycle(input bit r, input bit we, input logic [PW-1:0] cp,
                         input logic [FW-1:0] cpm, input bit v,
                         input logic [PW-1:0] p, input logic [FW-1:0] f);
        @(negedge clk);
        compare_outputs();
        rst = r; cfg_we = we; cfg_profile = cp; cfg_perm = cpm;
        req_valid = v; req_profile = p; req_func = f;
        #1;
        if (live || r) check("req_ready", req_ready, (!r && lock_m == 0));
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic req(input logic [PW-1:0] p, input logic [FW-1:0] f);
        cycle(1'b0, 1'b0, 3'd0, 3'd0, 1'b1, p, f);
    endtask

    task automatic idle_cycle();
        cycle(1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 3'd0);
    endtask

    logic [FW-1:0]  b2b_func  [4];
    logic [FW-1:0]  b2b_exp   [4];
    logic [FCW-1:0] b2b_fail  [4];

    initial begin
        cycle(1'b1, 1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 3'd0);
        cycle(1'b1, 1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 3'd0);
        check("reset_valid", resp_valid, 1'b0);
        check("reset_fail",  fail_count, 2'd0);
        check("reset_lock",  locked,     1'b0);

        // 1: empty table denies
        req(3'd5, 3'b010);
        check("t1_valid", resp_valid, 1'b1);
        check("t1_grant", resp_grant, 1'b0);
        check("t1_func",  resp_func,  3'b000);
        check("t1_fail",  fail_count, 2'd1);

        // 2: program profile 5, grant then deny
        cycle(1'b0, 1'b1, 3'd5, 3'b011, 1'b0, 3'd0, 3'd0);
        req(3'd5, 3'b010);
        check("t2_grant", resp_grant, 1'b1);
        check("t2_func",  resp_func,  3'b010);
        check("t2_fail",  fail_count, 2'd0);
        req(3'd5, 3'b110);
        check("t2_deny",  resp_grant, 1'b0);
        check("t2_dfunc", resp_func,  3'b000);

        // 3: same-cycle write is not seen by the request
        cycle(1'b0, 1'b1, 3'd2, 3'b100, 1'b1, 3'd2, 3'b100);
        check("t3_old",   resp_grant, 1'b0);
        check("t3_fail",  fail_count, 2'd2);
        req(3'd2, 3'b100);
        check("t3_new",   resp_grant, 1'b1);
        check("t3_func",  resp_func,  3'b100);

        // 4: three denials -> lockout of exactly LC cycles
        req(3'd0, 3'b001); req(3'd0, 3'b001); req(3'd0, 3'b001);
        check("t4_valid", resp_valid, 1'b1);
        check("t4_lock",  locked,     1'b1);
        check("t4_ready", req_ready,  1'b0);
        check("t4_fail",  fail_count, 2'd3);
        for (int i = 1; i <= LC; i++) begin
            req(3'd5, 3'b010);
            check("t4_ignored", resp_valid, 1'b0);
            if (i == LC - 1) check("t4_still_locked", locked, 1'b1);
        end
        check("t4_unlock", locked,     1'b0);
        check("t4_clear",  fail_count, 2'd0);
        req(3'd5, 3'b010);
        check("t4_accept", resp_valid, 1'b1);
        check("t4_agrant", resp_grant, 1'b1);

        // 5: back-to-back grant/deny/grant/deny
        b2b_func[0] = 3'b010; b2b_func[1] = 3'b100; b2b_func[2] = 3'b001; b2b_func[3] = 3'b110;
        b2b_exp[0]  = 3'b010; b2b_exp[1]  = 3'b000; b2b_exp[2]  = 3'b001; b2b_exp[3]  = 3'b000;
        b2b_fail[0] = 2'd0;   b2b_fail[1] = 2'd1;   b2b_fail[2] = 2'd0;   b2b_fail[3] = 2'd1;
        for (int i = 0; i < 4; i++) begin
            req(3'd5, b2b_func[i]);
            check("t5_valid", resp_valid, 1'b1);
            check("t5_func",  resp_func,  b2b_exp[i]);
            check("t5_fail",  fail_count, b2b_fail[i]);
        end

        // 6: reset in the middle of a lockout clears the table
        req(3'd0, 3'b001); req(3'd0, 3'b001);
        check("t6_lock", locked, 1'b1);
        idle_cycle(); idle_cycle(); idle_cycle();
        cycle(1'b1, 1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 3'd0);
        check("t6_unlock", locked,     1'b0);
        check("t6_nvalid", resp_valid, 1'b0);
        req(3'd5, 3'b010);
        check("t6_valid", resp_valid, 1'b1);
        check("t6_deny",  resp_grant, 1'b0);

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            cycle($urandom_range(0, 59) == 0, $urandom_range(0, 3) == 0,
                  3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                  $urandom_range(0, 3) != 0,
                  3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
        end

        @(negedge clk);
        compare_outputs();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
